// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-bundle input and encoded-word output handshakes.
// master = producer/consumer side, slave = encoder side.
interface instr_encoder_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [6:0]       in_opcode;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;

  modport master (
    output in_valid, in_fmt, in_opcode,
    output in_funct3, in_funct7,
    output in_rd, in_rs1, in_rs2, in_imm,
    output out_ready,
    input  in_ready, out_valid,
    input  out_instr, out_err, enc_count
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode,
    input  in_funct3, in_funct7,
    input  in_rd, in_rs1, in_rs2, in_imm,
    input  out_ready,
    output in_ready, out_valid,
    output out_instr, out_err, enc_count
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into words behind an output FIFO.
// Define IMM_CHECK_EN to flag out-of-range immediates in out_err.
module instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input logic            clk,
  input logic            rst,
  instr_encoder_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ?
    $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] OCC_FULL =
    (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;

  assign op  = bus.in_opcode;
  assign f3  = bus.in_funct3;
  assign f7  = bus.in_funct7;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign imm = bus.in_imm;

  logic is_r, is_i, is_s;
  logic is_b, is_u, is_j;

  assign is_r = (bus.in_fmt == FMT_R);
  assign is_i = (bus.in_fmt == FMT_I);
  assign is_s = (bus.in_fmt == FMT_S);
  assign is_b = (bus.in_fmt == FMT_B);
  assign is_u = (bus.in_fmt == FMT_U);
  assign is_j = (bus.in_fmt == FMT_J);

  logic [31:0] word;
  logic        fmt_bad;
  logic        imm_bad;
  logic        enc_err;

  // illegal formats fall through to the canonical NOP
  always_comb begin
    word    = 32'h0000_0013;
    fmt_bad = 1'b0;
    unique case (1'b1)
      is_r: word = {f7, rs2, rs1, f3, rd, op};
      is_i: word = {imm[11:0], rs1, f3, rd, op};
      is_s: word = {imm[11:5], rs2, rs1, f3,
                    imm[4:0], op};
      is_b: word = {imm[12], imm[10:5], rs2, rs1,
                    f3, imm[4:1], imm[11], op};
      is_u: word = {imm[31:12], rd, op};
      is_j: word = {imm[20], imm[10:1], imm[11],
                    imm[19:12], rd, op};
      default: fmt_bad = 1'b1;
    endcase
  end

`ifdef IMM_CHECK_EN
  logic sx11, sx12, sx20;

  assign sx11 = (&imm[31:11]) | ~(|imm[31:11]);
  assign sx12 = (&imm[31:12]) | ~(|imm[31:12]);
  assign sx20 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    imm_bad = 1'b0;
    unique case (1'b1)
      is_i, is_s: imm_bad = !sx11;
      is_b:       imm_bad = !sx12 || imm[0];
      is_j:       imm_bad = !sx20 || imm[0];
      is_u:       imm_bad = |imm[11:0];
      default:    imm_bad = 1'b0;
    endcase
  end
`else
  logic unused_imm0;

  assign unused_imm0 = imm[0];
  assign imm_bad     = 1'b0;
`endif

  assign enc_err = fmt_bad | imm_bad;

  logic [32:0]      mem_q [FIFO_DEPTH];
  logic [32:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      occ_q, occ_d;
  logic [32:0]      last_q, last_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
  logic             push, pop;
  logic             full, empty;
  logic [32:0]      head;

  assign full  = (occ_q == OCC_FULL);
  assign empty = (occ_q == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && bus.out_ready;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    last_d    = last_q;
    enc_cnt_d = enc_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {enc_err, word};
      wr_ptr_d        = wr_ptr_q + 1'b1;
      enc_cnt_d       = enc_cnt_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = head;
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      last_q    <= '0;
      enc_cnt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      last_q    <= last_d;
      enc_cnt_q <= enc_cnt_d;
    end
  end

  // once drained, the last popped entry stays visible
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_instr = empty ? last_q[31:0] : head[31:0];
  assign bus.out_err   = empty ? last_q[32] : head[32];
  assign bus.enc_count = enc_cnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: random and directed stimulus against a queue model
// of the encoder FIFO, plus literal encodings of known instructions.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic clk;
  logic rst;

  instr_encoder_if #(.CNT_W(CW)) bus ();

  instr_encoder #(
    .FIFO_DEPTH(DEPTH),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  function automatic logic [32:0] model_enc(
    logic [2:0] fmt, logic [6:0] op,
    logic [2:0] f3, logic [6:0] f7,
    logic [4:0] rd, logic [4:0] rs1,
    logic [4:0] rs2, logic [31:0] imm);
    logic [31:0] w;
    logic        e;
    logic        ok;
    int          s;
    s  = $signed(imm);
    e  = 1'b0;
    ok = 1'b1;
    case (fmt)
      3'd0: w = {f7, rs2, rs1, f3, rd, op};
      3'd1: begin
        w  = {imm[11:0], rs1, f3, rd, op};
        ok = (s >= -2048) && (s <= 2047);
      end
      3'd2: begin
        w  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        ok = (s >= -2048) && (s <= 2047);
      end
      3'd3: begin
        w  = {imm[12], imm[10:5], rs2, rs1, f3,
              imm[4:1], imm[11], op};
        ok = (s >= -4096) && (s <= 4095)
             && (s % 2 == 0);
      end
      3'd4: begin
        w  = {imm[31:12], rd, op};
        ok = (imm % 4096) == 0;
      end
      3'd5: begin
        w  = {imm[20], imm[10:1], imm[11],
              imm[19:12], rd, op};
        ok = (s >= -(1 << 20)) && (s < (1 << 20))
             && (s % 2 == 0);
      end
      default: begin
        w = 32'h0000_0013;
        e = 1'b1;
      end
    endcase
`ifdef IMM_CHECK_EN
    e = e | !ok;
`else
    if (ok) e = e;
`endif
    return {e, w};
  endfunction

  logic [32:0]   mq[$];
  logic [32:0]   m_last;
  logic [CW-1:0] m_cnt;
  bit            m_full;
  bit            cmp_en;
  logic [32:0]   cexp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_last = '0;
      m_cnt  = '0;
    end else begin
      m_full = (mq.size() == DEPTH);
      if (mq.size() != 0 && bus.out_ready)
        m_last = mq.pop_front();
      if (bus.in_valid && !m_full) begin
        mq.push_back(model_enc(
          bus.in_fmt, bus.in_opcode,
          bus.in_funct3, bus.in_funct7,
          bus.in_rd, bus.in_rs1,
          bus.in_rs2, bus.in_imm));
        m_cnt = m_cnt + 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      cexp = (mq.size() != 0) ? mq[0] : m_last;
      chk("out_valid", 32'(bus.out_valid),
          32'(mq.size() != 0));
      chk("in_ready", 32'(bus.in_ready),
          32'(mq.size() < DEPTH));
      chk("out_instr", bus.out_instr, cexp[31:0]);
      chk("out_err", 32'(bus.out_err), 32'(cexp[32]));
      chk("enc_count", 32'(bus.enc_count), 32'(m_cnt));
    end
  end

  task automatic set_f(logic [2:0] fmt,
                       logic [6:0] op,
                       logic [2:0] f3,
                       logic [6:0] f7,
                       logic [4:0] rd,
                       logic [4:0] rs1,
                       logic [4:0] rs2,
                       logic [31:0] imm);
    bus.in_fmt    = fmt;
    bus.in_opcode = op;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return r;
      1: return {{20{r[11]}}, r[11:0]};
      2: return {{19{r[12]}}, r[12:1], 1'b0};
      default: return {r[19:0], 12'h000};
    endcase
  endfunction

  task automatic rand_f(int max_fmt);
    set_f(3'($urandom_range(0, max_fmt)),
          7'($urandom), 3'($urandom),
          7'($urandom), 5'($urandom),
          5'($urandom), 5'($urandom),
          rand_imm());
  endtask

  task automatic push_one();
    logic rdy;
    bit   done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) done = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    cmp_en        = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_f(3'd0, 7'd0, 3'd0, 7'd0,
          5'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_enc_count", 32'(bus.enc_count), 32'd0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    set_f(3'd0, 7'h33, 3'd0, 7'd0,
          5'd3, 5'd1, 5'd2, 32'd0);
    push_one();
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_word", bus.out_instr, 32'h002081B3);
    chk("add_err", 32'(bus.out_err), 32'd0);
    pop_one();
    chk("add_hold", bus.out_instr, 32'h002081B3);
    chk("empty_valid", 32'(bus.out_valid), 32'd0);

    set_f(3'd1, 7'h13, 3'd0, 7'd0,
          5'd1, 5'd2, 5'd0, 32'd5);
    push_one();
    set_f(3'd2, 7'h23, 3'd2, 7'd0,
          5'd0, 5'd1, 5'd2, 32'd4);
    push_one();
    chk("addi_word", bus.out_instr, 32'h00510093);
    pop_one();
    chk("sw_word", bus.out_instr, 32'h0020A223);
    pop_one();

    set_f(3'd3, 7'h63, 3'd0, 7'd0,
          5'd0, 5'd1, 5'd2, 32'd8);
    push_one();
    chk("beq_word", bus.out_instr, 32'h00208463);
    pop_one();
    set_f(3'd5, 7'h6F, 3'd0, 7'd0,
          5'd1, 5'd0, 5'd0, 32'd2048);
    push_one();
    chk("jal_word", bus.out_instr, 32'h001000EF);
    pop_one();
`ifdef IMM_CHECK_EN
    set_f(3'd3, 7'h63, 3'd0, 7'd0,
          5'd0, 5'd1, 5'd2, 32'd7);
    push_one();
    chk("beq_odd_err", 32'(bus.out_err), 32'd1);
    pop_one();
`endif

    do_reset();
    for (int k = 1; k <= 4; k++) begin
      set_f(3'd1, 7'h13, 3'd0, 7'd0,
            5'd1, 5'd2, 5'd0, 32'(k));
      push_one();
    end
    set_f(3'd1, 7'h13, 3'd0, 7'd0,
          5'd1, 5'd2, 5'd0, 32'd5);
    bus.in_valid = 1'b1;
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    chk("full_count", 32'(bus.enc_count), 32'd4);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("pop_ready", 32'(bus.in_ready), 32'd1);
    chk("pop_count", 32'(bus.enc_count), 32'd4);
    chk("pop_head", bus.out_instr, 32'h00210093);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("refill_count", 32'(bus.enc_count), 32'd5);
    chk("refill_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    bus.out_ready = 1'b0;
    chk("drain_last", bus.out_instr, 32'h00510093);

    do_reset();
    set_f(3'd7, 7'h33, 3'd1, 7'd5,
          5'd9, 5'd8, 5'd7, 32'hDEAD_BEEF);
    push_one();
    chk("ill_word", bus.out_instr, 32'h00000013);
    chk("ill_err", 32'(bus.out_err), 32'd1);
    pop_one();
    for (int k = 0; k < 3; k++) begin
      rand_f(5);
      push_one();
    end
    rand_f(5);
    bus.in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_count", 32'(bus.enc_count), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_count", 32'(bus.enc_count), 32'd0);
    chk("post_rst_instr", bus.out_instr, 32'd0);

    repeat (3000) begin
      @(negedge clk);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      rand_f(7);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      rand_f(7);
      @(negedge clk);
    end
    chk("cnt_max", 32'(bus.enc_count), 32'h0000FFFF);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("cnt_wrap", 32'(bus.enc_count), 32'd0);
    repeat (3) @(negedge clk);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
